bfup_prog_loader: RTL and testbench
===================================

Name: bfup_prog_loader

Overview:
- Program loader and instruction-memory bus owner for the brainfuck CPU.
- Holds the CPU in reset, takes a host byte stream over a valid/ready handshake, and writes it into instruction RAM from address 0.
- Releases the CPU once a terminator byte arrives or memory is full.
- Sits between the host UART receiver, the instruction SRAM, and the CPU reset pin. The CPU tri-states its pc pins while its reset is low; that is when this block owns the address bus.

Parameters:
- ADDR_W, 18, instruction address width (matches the CPU pc).
- MAX_ADDR, 18'h3FFFF, last writable instruction address.
- TERM, 8'h00, terminator byte; it is written to memory, then loading ends.
- GAP, 4, bus turnaround cycles before driving and after releasing the bus.

Ports:
- clk  in  1  system clock, same as the CPU clock.
- reset  in  1  synchronous, active-low.
- load_req  in  1  single-cycle pulse: halt the CPU and start a new load.
- rx_valid  in  1  host byte valid.
- rx_data  in  8  host byte.
- rx_ready  out  1  loader accepts a byte this cycle.
- imem_addr  out  ADDR_W  instruction RAM address; high-Z when imem_drive=0.
- imem_wdata  out  8  instruction RAM write data; high-Z when imem_drive=0.
- imem_we_n  out  1  instruction RAM write strobe, active-low.
- imem_drive  out  1  loader owns the instruction bus.
- cpu_reset_n  out  1  CPU reset, active-low.
- busy  out  1  high whenever state != RUN.
- prog_len  out  ADDR_W  number of bytes written by the last load, terminator included.
- overflow  out  1  last load hit MAX_ADDR without seeing TERM; sticky until the next load.

Behaviour:
- Reset (reset=0, sampled on the clock edge):
  - state=HALT, cpu_reset_n=0, imem_drive=0, imem_we_n=1, rx_ready=0.
  - addr=0, prog_len=0, overflow=0, gap counter=GAP.
- States:
  - HALT: cpu_reset_n=0. Count down GAP cycles with the bus undriven. At 0: imem_drive=1, addr=0, overflow=0, go WAIT.
  - WAIT: rx_ready=1. On rx_valid&rx_ready, latch rx_data into imem_wdata and go SETUP. The handshake completes in the same cycle; rx_ready drops next cycle.
  - SETUP: address and data stable, imem_we_n=1. Go STROBE.
  - STROBE: imem_we_n=0 for exactly 1 cycle. Go HOLD.
  - HOLD: imem_we_n=1, prog_len=addr+1. Exit by priority:
    - data==TERM: go DONE.
    - else addr==MAX_ADDR: overflow=1, go DONE.
    - else: addr+1, go WAIT.
  - DONE: imem_drive=0 on entry. Count GAP cycles, then cpu_reset_n=1 and go RUN.
  - RUN: cpu_reset_n=1, imem_drive=0, rx_ready=0. A load_req pulse goes to HALT; cpu_reset_n drops the next cycle.
- Throughput: at most 1 byte per 4 cycles (WAIT/SETUP/STROBE/HOLD).
- Address rules: no wrap past MAX_ADDR. Address arithmetic is ADDR_W bits, unsigned.
- load_req outside RUN is ignored; there is no restart mid-load.
- rx_valid outside WAIT is not accepted (rx_ready=0). The host must hold the byte.
- Simultaneous load_req and rx_valid in RUN: load_req wins; the byte is not consumed.
- Reset mid-load, including during STROBE:
  - imem_we_n returns to 1 on that edge.
  - The bus is released and the block returns to HALT.
  - RAM contents are undefined at the interrupted address.
- Invariants:
  - imem_drive=1 never while cpu_reset_n=1.
  - At least GAP cycles always separate the two.

Optional Feature:
- CHECKSUM_EN defined:
  - Adds output csum[7:0], the mod-256 sum of all bytes written in the current load, terminator included.
  - csum clears in HALT and updates in HOLD.
  - Adds output csum_valid, high in RUN after a completed load; cleared by load_req or reset.
- CHECKSUM_EN undefined:
  - Neither port exists; no checksum logic.

Test Plan:
- Reset low 2 cycles, then high; send "+[-]" then 8'h00 -> RAM[0..4]=2B 5B 2D 5D 00; prog_len=5; overflow=0; cpu_reset_n rises exactly GAP cycles after imem_drive falls.
- Byte accept timing: rx_valid held high continuously -> accepts spaced exactly 4 cycles apart; imem_we_n low exactly 1 cycle per byte, with address/data stable one cycle before and one cycle after the strobe.
- Overflow: MAX_ADDR=3; send 2B 2B 2B 2B 2B with no terminator -> 4 writes at addresses 0-3; overflow=1; prog_len=4; fifth byte never accepted.
- load_req in RUN with rx_valid=1 in the same cycle -> CPU halted next cycle; that byte is not accepted until WAIT is reached after GAP cycles.
- Reset asserted during STROBE -> next edge gives imem_we_n=1, imem_drive=0, state HALT; a new load rewrites from addr 0.
- CHECKSUM_EN: send 01 02 FF 00 -> csum=8'h02, csum_valid=1 in RUN; a following load_req clears csum_valid.

Source files
------------

// File: rtl/bfup_prog_loader.sv
// Program loader for the brainfuck CPU: holds the CPU in reset, streams host bytes into
// instruction RAM from address 0, then releases the bus and the CPU. Optional macro CHECKSUM_EN.
//
// state    | meaning
// S_HALT   | CPU held in reset, bus undriven, turnaround countdown
// S_WAIT   | bus driven, waiting for a host byte (rx_ready=1)
// S_SETUP  | address/data stable ahead of the write strobe
// S_STROBE | imem_we_n low for one cycle
// S_HOLD   | address/data held after the strobe; decide next byte or finish
// S_DONE   | bus released, turnaround countdown before CPU release
// S_RUN    | CPU running, loader idle until load_req
module bfup_prog_loader #(
  parameter int                ADDR_W   = 18,
  parameter logic [ADDR_W-1:0] MAX_ADDR = 18'h3FFFF,
  parameter logic [7:0]        TERM     = 8'h00,
  parameter int                GAP      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_req,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [7:0]        imem_wdata,
  output logic              imem_we_n,
  output logic              imem_drive,
  output logic              cpu_reset_n,
`ifdef CHECKSUM_EN
  output logic [7:0]        csum,
  output logic              csum_valid,
`endif
  output logic              busy,
  output logic [ADDR_W-1:0] prog_len,
  output logic              overflow
);

  localparam int GAP_W = (GAP < 2) ? 1 : $clog2(GAP + 1);
  localparam logic [GAP_W-1:0] GAP_INIT = GAP_W'(GAP);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(1);

  typedef enum logic [2:0] {
    S_HALT   = 3'd0,
    S_WAIT   = 3'd1,
    S_SETUP  = 3'd2,
    S_STROBE = 3'd3,
    S_HOLD   = 3'd4,
    S_DONE   = 3'd5,
    S_RUN    = 3'd6
  } state_t;

  state_t            state, state_nx;
  logic [GAP_W-1:0]  gap_cnt;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        wdata;

  always_comb begin
    state_nx = state;
    unique case (state)
      S_HALT:   if (gap_cnt == GAP_LAST) state_nx = S_WAIT;
      S_WAIT:   if (rx_valid) state_nx = S_SETUP;
      S_SETUP:  state_nx = S_STROBE;
      S_STROBE: state_nx = S_HOLD;
      S_HOLD:   state_nx = (wdata == TERM || addr == MAX_ADDR) ? S_DONE : S_WAIT;
      S_DONE:   if (gap_cnt == GAP_LAST) state_nx = S_RUN;
      S_RUN:    if (load_req) state_nx = S_HALT;
      default:  state_nx = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= S_HALT;
      gap_cnt  <= GAP_INIT;
      addr     <= '0;
      wdata    <= '0;
      prog_len <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      // Counter runs only in the two turnaround states and is reloaded everywhere else,
      // so each entry into HALT or DONE starts a fresh GAP-cycle window.
      if (state == S_HALT || state == S_DONE)
        gap_cnt <= gap_cnt - 1'b1;
      else
        gap_cnt <= GAP_INIT;

      if (state == S_HALT && state_nx == S_WAIT) begin
        addr     <= '0;
        overflow <= 1'b0;
      end
      if (state == S_WAIT && rx_valid)
        wdata <= rx_data;
      if (state == S_HOLD) begin
        prog_len <= addr + 1'b1;
        if (wdata != TERM) begin
          if (addr == MAX_ADDR)
            overflow <= 1'b1;
          else
            addr <= addr + 1'b1;
        end
      end
    end
  end

`ifdef CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      csum       <= '0;
      csum_valid <= 1'b0;
    end else begin
      if (state == S_HALT)
        csum <= '0;
      else if (state == S_HOLD)
        csum <= csum + wdata;
      if (state == S_RUN && load_req)
        csum_valid <= 1'b0;
      else if (state == S_DONE && state_nx == S_RUN)
        csum_valid <= 1'b1;
    end
  end
`endif

  // All bus-facing controls decode straight from the state, so a reset edge drops the
  // strobe and releases the bus on that same edge.
  assign rx_ready    = (state == S_WAIT);
  assign imem_drive  = (state == S_WAIT) || (state == S_SETUP) ||
                       (state == S_STROBE) || (state == S_HOLD);
  assign imem_we_n   = (state != S_STROBE);
  assign cpu_reset_n = (state == S_RUN);
  assign busy        = (state != S_RUN);
  assign imem_addr   = imem_drive ? addr  : {ADDR_W{1'bz}};
  assign imem_wdata  = imem_drive ? wdata : 8'bz;

endmodule

// File: tb/tb_bfup_prog_loader.sv
// Self-checking bench for bfup_prog_loader: vector table, corner-case sequences and random loads
// checked against a byte-stream model of the load rules.
module tb_bfup_prog_loader;
  localparam int ADDR_W = 18;
  localparam int GAP    = 4;
  localparam int DEPTH  = 16;

  logic clk = 1'b0, reset = 1'b0, load_req = 1'b0, rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  wire rx_ready, imem_we_n, imem_drive, cpu_reset_n, busy, overflow;
  wire [ADDR_W-1:0] imem_addr, prog_len;
  wire [7:0] imem_wdata;
`ifdef CHECKSUM_EN
  wire [7:0] csum;
  wire csum_valid;
`endif

  bfup_prog_loader #(
    .ADDR_W(ADDR_W), .MAX_ADDR(18'(DEPTH - 1)), .TERM(8'h00), .GAP(GAP)
  ) dut (
    .clk(clk), .reset(reset), .load_req(load_req), .rx_valid(rx_valid), .rx_data(rx_data),
    .rx_ready(rx_ready), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .imem_we_n(imem_we_n), .imem_drive(imem_drive), .cpu_reset_n(cpu_reset_n),
`ifdef CHECKSUM_EN
    .csum(csum), .csum_valid(csum_valid),
`endif
    .busy(busy), .prog_len(prog_len), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0, cyc = 0;
  int acc_n = 0, strobe_n = 0;
  int acc_cyc[$];
  logic [7:0] tb_mem [DEPTH];
  logic [7:0] tx_q[$];
  int exp_len; bit exp_ovf; logic [7:0] exp_csum;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Handshake observer: looks after the driver has settled, ahead of the next rising edge.
  always @(negedge clk) begin
    #2;
    if (reset && rx_valid && rx_ready) begin
      acc_n++;
      acc_cyc.push_back(cyc + 1);
    end
  end

  // Bus observer: write capture, strobe shape and turnaround spacing.
  logic prev_we_n = 1'b1, prev_drive = 1'b0, prev_cpu = 1'b0, post_chk = 1'b0;
  logic [ADDR_W-1:0] prev_addr = '0, st_addr = '0;
  logic [7:0] prev_data = '0, st_data = '0;
  int drive_fall = -1, cpu_fall = -1;
  always @(negedge clk) begin
    if (reset) begin
      if (post_chk) begin
        post_chk = 1'b0;
        chk("hold_addr", imem_addr, st_addr);
        chk("hold_data", imem_wdata, st_data);
        chk("hold_we_n", imem_we_n, 1);
      end
      if (!imem_we_n) begin
        strobe_n++;
        chk("strobe_single", prev_we_n, 1);
        chk("setup_drive", prev_drive, 1);
        chk("setup_addr", prev_addr, imem_addr);
        chk("setup_data", prev_data, imem_wdata);
        if (int'(imem_addr) < DEPTH) tb_mem[int'(imem_addr)] = imem_wdata;
        else chk("strobe_addr_range", imem_addr, DEPTH - 1);
        st_addr = imem_addr; st_data = imem_wdata; post_chk = 1'b1;
      end
      if (prev_drive && !imem_drive) drive_fall = cyc;
      if (!prev_cpu && cpu_reset_n && drive_fall >= 0) chk("release_gap", cyc - drive_fall, GAP);
      if (prev_cpu && !cpu_reset_n) cpu_fall = cyc;
      if (!prev_drive && imem_drive && cpu_fall >= 0) chk("drive_gap", cyc - cpu_fall, GAP);
      if (imem_drive && cpu_reset_n) chk("bus_conflict", 1, 0);
    end else begin
      post_chk = 1'b0; drive_fall = -1; cpu_fall = -1;
    end
    prev_we_n = imem_we_n; prev_drive = imem_drive; prev_cpu = cpu_reset_n;
    prev_addr = imem_addr; prev_data = imem_wdata;
  end

  task automatic step();
    @(negedge clk); #1;
  endtask

  task automatic clear_obs();
    acc_n = 0; strobe_n = 0; acc_cyc.delete();
    for (int i = 0; i < DEPTH; i++) tb_mem[i] = 8'hEE;
  endtask

  task automatic wait_run();
    int t = 0;
    while (busy && t < 200) begin step(); t++; end
    if (busy) chk("run_timeout", 1, 0);
  endtask

  // Host side: present each queued byte until taken or until the loader finishes.
  task automatic do_load(input bit with_req, input int gap_max);
    int start, t;
    clear_obs();
    if (with_req) begin
      load_req = 1'b1; step(); load_req = 1'b0;
`ifdef CHECKSUM_EN
      chk("csum_valid_clr", csum_valid, 0);
`endif
    end
    for (int i = 0; i < tx_q.size(); i++) begin
      if (gap_max > 0) begin
        rx_valid = 1'b0;
        repeat ($urandom_range(gap_max, 0)) begin
          load_req = ($urandom_range(3, 0) == 0);
          step();
          load_req = 1'b0;
        end
      end
      rx_valid = 1'b1; rx_data = tx_q[i];
      start = acc_n; t = 0;
      while (acc_n == start && busy && t < 80) begin step(); t++; end
      if (!busy) break;
      if (t >= 80) begin chk("accept_timeout", 1, 0); break; end
    end
    wait_run();
    rx_valid = 1'b0;
    if (gap_max == 0)
      for (int k = 1; k < acc_cyc.size(); k++) chk("accept_spacing", acc_cyc[k] - acc_cyc[k-1], 4);
  endtask

  task automatic check_load(input string nm);
    chk({nm, "_prog_len"}, prog_len, exp_len);
    chk({nm, "_overflow"}, overflow, exp_ovf);
    chk({nm, "_accepts"}, acc_n, exp_len);
    chk({nm, "_strobes"}, strobe_n, exp_len);
    chk({nm, "_cpu_run"}, cpu_reset_n, 1);
    chk({nm, "_bus_free"}, imem_drive, 0);
    for (int i = 0; i < exp_len && i < DEPTH; i++) chk({nm, "_mem"}, tb_mem[i], tx_q[i]);
`ifdef CHECKSUM_EN
    chk({nm, "_csum"}, csum, exp_csum);
    chk({nm, "_csum_valid"}, csum_valid, 1);
`endif
  endtask

  // Model: bytes are stored until and including the first terminator, capped at DEPTH.
  task automatic model();
    exp_len = 0; exp_ovf = 1'b1; exp_csum = 8'h00;
    foreach (tx_q[i]) begin
      if (exp_len == DEPTH) break;
      exp_len++;
      exp_csum = exp_csum + tx_q[i];
      if (tx_q[i] == 8'h00) begin exp_ovf = 1'b0; break; end
    end
  endtask

  typedef struct {
    int len;
    logic [7:0] d [20];
    int e_len;
    bit e_ovf;
    logic [7:0] e_csum;
  } vec_t;
  vec_t vt [5];

  initial begin : main
    int c0, t;
    for (int v = 0; v < 5; v++) for (int i = 0; i < 20; i++) vt[v].d[i] = 8'h00;
    vt[0].len = 5; vt[0].d[0] = 8'h2B; vt[0].d[1] = 8'h5B; vt[0].d[2] = 8'h2D; vt[0].d[3] = 8'h5D;
    vt[0].e_len = 5; vt[0].e_ovf = 0; vt[0].e_csum = 8'h10;
    vt[1].len = 4; vt[1].d[0] = 8'h01; vt[1].d[1] = 8'h02; vt[1].d[2] = 8'hFF;
    vt[1].e_len = 4; vt[1].e_ovf = 0; vt[1].e_csum = 8'h02;
    vt[2].len = 1; vt[2].e_len = 1; vt[2].e_ovf = 0; vt[2].e_csum = 8'h00;
    vt[3].len = 16; for (int i = 0; i < 15; i++) vt[3].d[i] = 8'h01;
    vt[3].e_len = 16; vt[3].e_ovf = 0; vt[3].e_csum = 8'h0F;
    vt[4].len = 17; for (int i = 0; i < 17; i++) vt[4].d[i] = 8'h2B;
    vt[4].e_len = 16; vt[4].e_ovf = 1; vt[4].e_csum = 8'hB0;

    step(); step();
    chk("rst_cpu_reset_n", cpu_reset_n, 0);
    chk("rst_drive", imem_drive, 0);
    chk("rst_we_n", imem_we_n, 1);
    chk("rst_rx_ready", rx_ready, 0);
    chk("rst_busy", busy, 1);
    chk("rst_prog_len", prog_len, 0);
    chk("rst_overflow", overflow, 0);
    reset = 1'b1;

    for (int v = 0; v < 5; v++) begin
      tx_q.delete();
      for (int i = 0; i < vt[v].len; i++) tx_q.push_back(vt[v].d[i]);
      exp_len = vt[v].e_len; exp_ovf = vt[v].e_ovf; exp_csum = vt[v].e_csum;
      do_load(v != 0, (v == 2) ? 3 : 0);
      check_load($sformatf("vec%0d", v));
    end

    // load_req and a byte together in RUN: request wins, byte waits for WAIT.
    clear_obs();
    load_req = 1'b1; rx_valid = 1'b1; rx_data = 8'h00;
    step(); load_req = 1'b0; c0 = cyc;
    chk("req_halts_cpu", cpu_reset_n, 0);
    chk("req_byte_not_taken", acc_n, 0);
    t = 0;
    while (acc_n == 0 && t < 40) begin step(); t++; end
    chk("req_accept_delay", (acc_cyc.size() > 0) ? acc_cyc[0] - c0 : -1, GAP + 1);
    wait_run(); rx_valid = 1'b0;
    chk("req_prog_len", prog_len, 1);

    // Reset landing on the write strobe.
    load_req = 1'b1; step(); load_req = 1'b0;
    rx_valid = 1'b1; rx_data = 8'h41; t = 0;
    while (imem_we_n && t < 40) begin step(); t++; end
    chk("strobe_seen", imem_we_n, 0);
    reset = 1'b0; rx_valid = 1'b0; step();
    chk("rststb_we_n", imem_we_n, 1);
    chk("rststb_drive", imem_drive, 0);
    chk("rststb_cpu", cpu_reset_n, 0);
    chk("rststb_busy", busy, 1);
    chk("rststb_prog_len", prog_len, 0);
    reset = 1'b1;
    tx_q.delete(); tx_q.push_back(8'h3E); tx_q.push_back(8'h00);
    exp_len = 2; exp_ovf = 0; exp_csum = 8'h3E;
    do_load(1'b0, 1);
    check_load("reload");

    for (int r = 0; r < 25; r++) begin
      int n = $urandom_range(20, 1);
      tx_q.delete();
      for (int i = 0; i < n; i++)
        tx_q.push_back(($urandom_range(5, 0) == 0) ? 8'h00 : 8'($urandom_range(255, 1)));
      tx_q.push_back(8'h00);
      model();
      do_load(1'b1, (r % 3 == 0) ? 0 : 3);
      check_load("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end
endmodule
